// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx: serial frame receiver with one-entry valid/ready output buffer
// clk       : system clock, rising edge
// rst       : asynchronous active-high reset
// a         : serial line, idles 0; start(1), D[0..WIDTH-1], optional even parity, stop(0)
// ready     : downstream accepts word when valid && ready
// q         : received word, stable while valid
// valid     : q/perr hold an unconsumed word
// perr      : parity error flag travelling with q
// frame_err : one-cycle pulse, stop bit sampled as 1
// overrun   : one-cycle pulse, good frame dropped because buffer was full
module sipo_frame_rx #(
   parameter int WIDTH     = 8,
   parameter int PARITY_EN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a,
   input  logic             ready,
   output logic [WIDTH-1:0] q,
   output logic             valid,
   output logic             perr,
   output logic             frame_err,
   output logic             overrun
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sr;
   logic             pbad;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         sr        <= '0;
         pbad      <= 1'b0;
         q         <= '0;
         valid     <= 1'b0;
         perr      <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         // a load in STOP below overrides this consumption
         if (valid && ready) valid <= 1'b0;
         case (state)
            IDLE: if (a) begin
               state <= DATA;
               cnt   <= '0;
               pbad  <= 1'b0;
            end
            DATA: begin
               // LSB arrives first, so shift right and enter at the top
               sr  <= {a, sr[WIDTH-1:1]};
               cnt <= cnt + 1'b1;
               if (cnt == LAST) state <= (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: begin
               pbad  <= (^sr) ^ a;
               state <= STOP;
            end
            default: begin
               state     <= IDLE;
               frame_err <= a;
               if (!a) begin
                  if (!valid || ready) begin
                     q     <= sr;
                     perr  <= pbad;
                     valid <= 1'b1;
                  end else overrun <= 1'b1;
               end
            end
         endcase
      end
endmodule

// File: tb/tb_sipo_frame_rx.sv
// tb_sipo_frame_rx: directed self-checking bench for sipo_frame_rx (WIDTH=8, PARITY_EN=1)
module tb_sipo_frame_rx;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       a = 1'b0;
   logic       ready = 1'b0;
   logic [7:0] q;
   logic       valid, perr, frame_err, overrun;
   int         n_cmp = 0;
   int         n_err = 0;
   sipo_frame_rx #(.WIDTH(8), .PARITY_EN(1)) dut (
      .clk(clk), .rst(rst), .a(a), .ready(ready), .q(q),
      .valid(valid), .perr(perr), .frame_err(frame_err), .overrun(overrun)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic send_bit(input logic b);
      a = b;
      @(posedge clk);
      #1;
   endtask
   task automatic tick();
      a = 1'b0;
      @(posedge clk);
      #1;
   endtask
   task automatic consume();
      ready = 1'b1;
      tick();
      ready = 1'b0;
   endtask
   // returns #1 after the stop-sample edge; rdy is the ready level at that edge
   task automatic send_frame(input logic [7:0] d, input logic p, input logic stop, input logic rdy);
      send_bit(1'b1);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(p);
      ready = rdy;
      send_bit(stop);
      ready = 1'b0;
      a = 1'b0;
   endtask
   initial begin
      tick();
      tick();
      check("rst_q", q, 8'h00);
      check("rst_valid", valid, 0);
      check("rst_perr", perr, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_ovr", overrun, 0);
      rst = 1'b0;
      tick();
      // 0xA5, parity 0, good stop
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
      check("a5_valid", valid, 1);
      check("a5_q", q, 8'hA5);
      check("a5_perr", perr, 0);
      check("a5_ferr", frame_err, 0);
      tick();
      check("a5_hold_valid", valid, 1);
      consume();
      check("a5_consumed", valid, 0);
      check("a5_q_kept", q, 8'hA5);
      // 0x07 has three ones so P should be 1; send 0
      send_frame(8'h07, 1'b0, 1'b0, 1'b0);
      check("07_q", q, 8'h07);
      check("07_valid", valid, 1);
      check("07_perr", perr, 1);
      check("07_ferr", frame_err, 0);
      consume();
      check("07_consumed", valid, 0);
      // 0x3C with bad stop bit
      send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
      check("3c_ferr", frame_err, 1);
      check("3c_valid", valid, 0);
      check("3c_q_kept", q, 8'h07);
      tick();
      check("3c_ferr_pulse", frame_err, 0);
      // back-to-back 0x11 then 0x22, no consumption: second frame overruns
      send_frame(8'h11, 1'b0, 1'b0, 1'b0);
      check("11_q", q, 8'h11);
      check("11_valid", valid, 1);
      check("11_ovr", overrun, 0);
      send_frame(8'h22, 1'b0, 1'b0, 1'b0);
      check("ovr_q", q, 8'h11);
      check("ovr_pulse", overrun, 1);
      check("ovr_ferr", frame_err, 0);
      check("ovr_valid", valid, 1);
      tick();
      check("ovr_pulse_end", overrun, 0);
      consume();
      check("ovr_consumed", valid, 0);
      // same pair, ready high at the second stop edge: replace without overrun
      send_frame(8'h11, 1'b0, 1'b0, 1'b0);
      check("rep11_q", q, 8'h11);
      send_frame(8'h22, 1'b0, 1'b0, 1'b1);
      check("rep22_q", q, 8'h22);
      check("rep22_valid", valid, 1);
      check("rep22_ovr", overrun, 0);
      // async reset after start + 4 data bits
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      a = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("arst_q", q, 8'h00);
      check("arst_valid", valid, 0);
      check("arst_perr", perr, 0);
      check("arst_ferr", frame_err, 0);
      check("arst_ovr", overrun, 0);
      #2 rst = 1'b0;
      tick();
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
      check("5a_q", q, 8'h5A);
      check("5a_valid", valid, 1);
      check("5a_perr", perr, 0);
      check("5a_ferr", frame_err, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
